radix4_seq_divider: RTL and testbench

- Parametrised, iterative, unsigned radix-4 integer divider for the FPU divide path.
- Successor to the single-stage combinational radix-4 divider step.
- Folds the step into one clocked datapath that retires 2 quotient bits per cycle.
- Adds a valid/ready handshake on both sides, a divide-by-zero flag, and support for any WIDTH, odd or even.

---
 rtl/radix4_seq_divider.sv | 173 +++++++++++++++++
 tb/tb_radix4_seq_divider.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/radix4_seq_divider.sv
// Iterative unsigned radix-4 divider: retires two quotient bits per clock,
// with valid/ready handshakes on both sides and a divide-by-zero flag.
module radix4_seq_divider #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DIV0
);

  localparam int K  = (WIDTH + 1) / 2;
  localparam int W2 = 2 * K;
  localparam int RW = WIDTH + 2;
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_rem;
  logic [W2-1:0]   r_dvd;
  logic [W2-1:0]   r_quo;
  logic [WIDTH-1:0] r_d;
  logic [RW-1:0]   r_d2;
  logic [RW-1:0]   r_d3;

  logic [RW-1:0]   w_d1;
  logic [RW-1:0]   w_t;
  logic [1:0]      w_digit;
  logic [RW-1:0]   w_rem_next;
  logic [W2-1:0]   w_quo_next;
  logic [W2-1:0]   w_dvd_next;
  logic            w_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_next = (D == {WIDTH{1'b0}}) ? S_DONE : S_CALC;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_CALC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // One radix-4 step: select the largest multiple of D that fits the shifted remainder
  always_comb begin
    w_d1       = RW'(r_d);
    w_t        = (r_rem << 2) | RW'(r_dvd[W2-1 -: 2]);
    w_digit    = 2'd0;
    w_rem_next = w_t;
    if (w_t >= r_d3) begin
      w_digit    = 2'd3;
      w_rem_next = w_t - r_d3;
    end else if (w_t >= r_d2) begin
      w_digit    = 2'd2;
      w_rem_next = w_t - r_d2;
    end else if (w_t >= w_d1) begin
      w_digit    = 2'd1;
      w_rem_next = w_t - w_d1;
    end else begin
      w_digit    = 2'd0;
      w_rem_next = w_t;
    end
    w_quo_next = (r_quo << 2) | W2'(w_digit);
    w_dvd_next = r_dvd << 2;
    w_last     = (r_cnt == CW'(1));
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
      r_rem <= {RW{1'b0}};
      r_dvd <= {W2{1'b0}};
      r_quo <= {W2{1'b0}};
      r_d   <= {WIDTH{1'b0}};
      r_d2  <= {RW{1'b0}};
      r_d3  <= {RW{1'b0}};
      Q     <= {WIDTH{1'b0}};
      R     <= {WIDTH{1'b0}};
      DIV0  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dvd <= W2'(N);
            r_d   <= D;
            r_d2  <= RW'(D) << 1;
            r_d3  <= RW'(D) + (RW'(D) << 1);
            r_rem <= {RW{1'b0}};
            r_quo <= {W2{1'b0}};
            r_cnt <= CW'(K);
            if (D == {WIDTH{1'b0}}) begin
              Q    <= {WIDTH{1'b1}};
              R    <= N;
              DIV0 <= 1'b1;
            end else begin
              DIV0 <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_dvd <= w_dvd_next;
          r_cnt <= r_cnt - CW'(1);
          // For odd WIDTH the extra top quotient bit is always zero and is dropped here
          if (w_last) begin
            Q <= w_quo_next[WIDTH-1:0];
            R <= w_rem_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_seq_divider.sv
// Scoreboard bench for radix4_seq_divider at WIDTH=10 (directed) and WIDTH=9 (directed + random).
module tb_radix4_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv10, ir10, ov10, or10, z10;
  logic [9:0] n10, d10, q10, r10;
  logic       iv9, ir9, ov9, or9, z9;
  logic [8:0] n9, d9, q9, r9;

  radix4_seq_divider #(.WIDTH(10)) u_div10 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10), .N(n10), .D(d10),
    .out_valid(ov10), .out_ready(or10), .Q(q10), .R(r10), .DIV0(z10)
  );

  radix4_seq_divider #(.WIDTH(9)) u_div9 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv9), .in_ready(ir9), .N(n9), .D(d9),
    .out_valid(ov9), .out_ready(or9), .Q(q9), .R(r9), .DIV0(z9)
  );

  typedef struct packed {
    logic [9:0] q;
    logic [9:0] r;
    logic       z;
  } exp_t;

  exp_t sb10[$];
  exp_t sb9[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the 10-bit instance: compare at every result handshake
  always @(negedge clk) begin : mon10
    exp_t e;
    if (rst_n && ov10 && or10) begin
      if (sb10.size() == 0) begin
        n_errors++;
        $display("FAIL w10 unexpected result: got Q=%0d R=%0d expected none", q10, r10);
      end else begin
        e = sb10.pop_front();
        check("w10 Q", q10, e.q);
        check("w10 R", r10, e.r);
        check("w10 DIV0", z10, e.z);
      end
    end
  end

  // Monitor for the 9-bit instance
  always @(negedge clk) begin : mon9
    exp_t e;
    if (rst_n && ov9 && or9) begin
      if (sb9.size() == 0) begin
        n_errors++;
        $display("FAIL w9 unexpected result: got Q=%0d R=%0d expected none", q9, r9);
      end else begin
        e = sb9.pop_front();
        check("w9 Q", q9, e.q);
        check("w9 R", r9, e.r);
        check("w9 DIV0", z9, e.z);
      end
    end
  end

  task automatic op10(input logic [9:0] n, input logic [9:0] d, input int hold,
                      input logic [9:0] eq, input logic [9:0] er, input logic ez);
    int lat;
    check("w10 in_ready idle", ir10, 1);
    n10 = n; d10 = d; iv10 = 1'b1; or10 = (hold == 0);
    sb10.push_back('{q: eq, r: er, z: ez});
    @(posedge clk); #1;
    iv10 = 1'b0; n10 = ~n; d10 = ~d;
    lat = 0;
    while (!ov10 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w10 latency", lat, ez ? 0 : 5);
    for (int i = 0; i < hold; i++) begin
      check("w10 in_ready busy", ir10, 0);
      check("w10 out_valid held", ov10, 1);
      check("w10 Q held", q10, eq);
      check("w10 R held", r10, er);
      iv10 = 1'b1; n10 = 10'(i * 3 + 1); d10 = 10'd2;
      @(posedge clk); #1;
    end
    iv10 = 1'b0; or10 = 1'b1;
    @(posedge clk); #1;
    check("w10 out_valid drop", ov10, 0);
    check("w10 in_ready back", ir10, 1);
  endtask

  task automatic op9(input logic [8:0] n, input logic [8:0] d,
                     input logic [9:0] eq, input logic [9:0] er, input logic ez);
    int lat;
    check("w9 in_ready idle", ir9, 1);
    n9 = n; d9 = d; iv9 = 1'b1; or9 = 1'b1;
    sb9.push_back('{q: eq, r: er, z: ez});
    @(posedge clk); #1;
    iv9 = 1'b0; n9 = ~n; d9 = ~d;
    lat = 0;
    while (!ov9 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w9 latency", lat, ez ? 0 : 5);
    @(posedge clk); #1;
    check("w9 out_valid drop", ov9, 0);
  endtask

  initial begin
    logic [8:0] rn, rd;
    rst_n = 1'b0;
    iv10 = 1'b0; or10 = 1'b0; n10 = '0; d10 = '0;
    iv9  = 1'b0; or9  = 1'b0; n9  = '0; d9  = '0;
    #1;
    check("reset out_valid", ov10, 0);
    check("reset Q", q10, 0);
    check("reset R", r10, 0);
    check("reset DIV0", z10, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("reset in_ready", ir10, 1);

    op10(10'd10,   10'd5,    0, 10'd2,    10'd0,  1'b0);
    op10(10'd342,  10'd14,   0, 10'd24,   10'd6,  1'b0);
    op10(10'd1023, 10'd1,    0, 10'd1023, 10'd0,  1'b0);
    op10(10'd3,    10'd1000, 0, 10'd0,    10'd3,  1'b0);
    op10(10'd37,   10'd0,    0, 10'd1023, 10'd37, 1'b1);
    op10(10'd20,   10'd3,    0, 10'd6,    10'd2,  1'b0);
    op10(10'd100,  10'd7,    4, 10'd14,   10'd2,  1'b0);
    op10(10'd0,    10'd0,    0, 10'd1023, 10'd0,  1'b1);
    op10(10'd0,    10'd5,    0, 10'd0,    10'd0,  1'b0);

    // Reset in the middle of a division: nothing must come out
    n10 = 10'd500; d10 = 10'd9; iv10 = 1'b1; or10 = 1'b1;
    @(posedge clk); #1;
    iv10 = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", ov10, 0);
    check("abort Q", q10, 0);
    check("abort R", r10, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("abort in_ready", ir10, 1);
    repeat (10) @(posedge clk);
    #1;
    op10(10'd500, 10'd9, 0, 10'd55, 10'd5, 1'b0);

    op9(9'd511, 9'd3, 10'd170, 10'd1, 1'b0);
    op9(9'd5,   9'd0, 10'd511, 10'd5, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      rn = 9'($urandom_range(0, 511));
      rd = 9'($urandom_range(0, 511));
      if (i % 50 == 0) rd = 9'd0;
      if (rd == 9'd0) op9(rn, rd, 10'd511, {1'b0, rn}, 1'b1);
      else            op9(rn, rd, {1'b0, rn / rd}, {1'b0, rn % rd}, 1'b0);
    end

    repeat (3) @(posedge clk);
    check("w10 scoreboard drained", sb10.size(), 0);
    check("w9 scoreboard drained", sb9.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
